// File: rtl/md_pkg.sv
// Shared md_op encodings for the multiply/divide unit, D-stage decoder and hazard unit.
// MD_UNIT_MADD_EN enables the multiply-accumulate ops (9-12) in is_multicycle().
package md_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8,
      MD_MADD  = 4'd9,
      MD_MADDU = 4'd10,
      MD_MSUB  = 4'd11,
      MD_MSUBU = 4'd12
   } md_op_e;

   function automatic logic is_multicycle(input logic [3:0] op);
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_UNIT_MADD_EN
         MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO; result is computed at start and committed after N busy cycles.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are built when MD_UNIT_MADD_EN is defined.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e           r_state;
   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_hi, r_lo;
   logic [63:0]      r_shadow;

   logic [63:0]      w_a_sx, w_b_sx, w_prod_s, w_prod_u, w_hilo, w_shadow;
   logic [31:0]      w_div_b, w_quot_s, w_rem_s, w_quot_u, w_rem_u;
   logic             w_b_zero;
   logic [CNT_W-1:0] w_load;

   assign w_a_sx   = {{32{rs_val[31]}}, rs_val};
   assign w_b_sx   = {{32{rt_val[31]}}, rt_val};
   assign w_prod_s = $signed(w_a_sx) * $signed(w_b_sx);
   assign w_prod_u = {32'b0, rs_val} * {32'b0, rt_val};
   assign w_hilo   = {r_hi, r_lo};

   // A zero divisor is swapped for 1 so the dividers never see x; its result is discarded below.
   assign w_b_zero = (rt_val == 32'd0);
   assign w_div_b  = w_b_zero ? 32'd1 : rt_val;
   assign w_quot_s = $signed(rs_val) / $signed(w_div_b);
   assign w_rem_s  = $signed(rs_val) % $signed(w_div_b);
   assign w_quot_u = rs_val / w_div_b;
   assign w_rem_u  = rs_val % w_div_b;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_shadow = w_hilo;
      w_load   = MULT_LOAD;
      case (md_op)
         MD_MULT:  w_shadow = w_prod_s;
         MD_MULTU: w_shadow = w_prod_u;
         MD_DIV: begin
            w_load = DIV_LOAD;
            if (!w_b_zero) w_shadow = {w_rem_s, w_quot_s};
         end
         MD_DIVU: begin
            w_load = DIV_LOAD;
            if (!w_b_zero) w_shadow = {w_rem_u, w_quot_u};
         end
`ifdef MD_UNIT_MADD_EN
         MD_MADD:  w_shadow = w_hilo + w_prod_s;
         MD_MADDU: w_shadow = w_hilo + w_prod_u;
         MD_MSUB:  w_shadow = w_hilo - w_prod_s;
         MD_MSUBU: w_shadow = w_hilo - w_prod_u;
`endif
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_shadow <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && is_multicycle(md_op)) begin
                  r_shadow <= w_shadow;
                  r_cnt    <= w_load;
                  r_busy   <= 1'b1;
                  r_state  <= S_RUN;
               end else if (start && md_op == MD_MTHI) begin
                  r_hi <= rs_val;
               end else if (start && md_op == MD_MTLO) begin
                  r_lo <= rs_val;
               end
            end
            S_RUN: begin
               if (r_cnt == '0) begin
                  r_hi    <= r_shadow[63:32];
                  r_lo    <= r_shadow[31:0];
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      md_out = 32'd0;
      case (md_op)
         MD_MFHI: md_out = r_hi;
         MD_MFLO: md_out = r_lo;
         default: ;
      endcase
   end

   assign busy     = r_busy;
   assign md_stall = r_busy | (start & is_multicycle(md_op));
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops against an arithmetic HI/LO model.
// Expectations for ops 9-12 follow MD_UNIT_MADD_EN, which must match the RTL build.
module tb_md_unit;
   import md_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  md_op = 4'd0;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        busy, md_stall;
   logic [31:0] hi, lo, md_out;

   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   int          n_pass = 0;
   int          n_total = 0;

   md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .md_stall(md_stall),
      .hi(hi), .lo(lo), .md_out(md_out)
   );

   always #5 clk = ~clk;

   // Reference model: applies one op to m_hi/m_lo from the arithmetic definition, returns busy cycles.
   function automatic int model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int          sa, sb;
      logic [63:0] ps, pu, acc;
      sa  = int'(a);
      sb  = int'(b);
      ps  = 64'(longint'(sa) * longint'(sb));
      pu  = 64'({32'd0, a}) * 64'({32'd0, b});
      acc = {m_hi, m_lo};
      case (op)
         MD_MULT:  begin {m_hi, m_lo} = ps; return MULT_N; end
         MD_MULTU: begin {m_hi, m_lo} = pu; return MULT_N; end
         MD_DIV: begin
            if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            return DIV_N;
         end
         MD_DIVU: begin
            if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            return DIV_N;
         end
         MD_MTHI: begin m_hi = a; return 0; end
         MD_MTLO: begin m_lo = a; return 0; end
`ifdef MD_UNIT_MADD_EN
         MD_MADD:  begin {m_hi, m_lo} = acc + ps; return MULT_N; end
         MD_MADDU: begin {m_hi, m_lo} = acc + pu; return MULT_N; end
         MD_MSUB:  begin {m_hi, m_lo} = acc - ps; return MULT_N; end
         MD_MSUBU: begin {m_hi, m_lo} = acc - pu; return MULT_N; end
`endif
         default: return 0;
      endcase
   endfunction

   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
      logic [31:0] old_hi, old_lo, exp_out;
      int          lat, cnt;
      old_hi  = m_hi;
      old_lo  = m_lo;
      exp_out = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'd0;
      lat     = model_apply(op, a, b);
      @(negedge clk);
      start = 1'b1; md_op = op; rs_val = a; rt_val = b;
      #1;
      n_total++;
      if (md_stall !== (lat > 0)) $display("FAIL %s md_stall: got %b want %b", name, md_stall, lat > 0);
      else n_pass++;
      n_total++;
      if (md_out !== exp_out) $display("FAIL %s md_out: got %h want %h", name, md_out, exp_out);
      else n_pass++;
      @(negedge clk);
      start = 1'b0; md_op = MD_NONE;
      if (lat > 0) begin
         n_total++;
         if (hi !== old_hi || lo !== old_lo)
            $display("FAIL %s hold during run: got %h_%h want %h_%h", name, hi, lo, old_hi, old_lo);
         else n_pass++;
         cnt = 0;
         while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
         end
         n_total++;
         if (cnt != lat) $display("FAIL %s busy cycles: got %0d want %0d", name, cnt, lat);
         else n_pass++;
      end else begin
         n_total++;
         if (busy !== 1'b0) $display("FAIL %s busy: got %b want 0", name, busy);
         else n_pass++;
      end
      n_total++;
      if (hi !== m_hi || lo !== m_lo)
         $display("FAIL %s hi/lo: got %h_%h want %h_%h", name, hi, lo, m_hi, m_lo);
      else n_pass++;
   endtask

   task automatic test_reset;
      #2;
      n_total++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || md_out !== 32'd0 || md_stall !== 1'b0)
         $display("FAIL reset state: got busy=%b hi=%h lo=%h md_out=%h want 0", busy, hi, lo, md_out);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mult;
      do_op(MD_MULT,  32'hFFFFFFFF, 32'd2, "mult -1x2");
      do_op(MD_MFHI,  32'd0, 32'd0, "mfhi after mult");
      do_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, "multu");
      do_op(MD_MFLO,  32'd0, 32'd0, "mflo after multu");
   endtask

   task automatic test_div;
      do_op(MD_DIV,  32'hFFFFFFF9, 32'd2, "div -7/2");
      do_op(MD_DIVU, 32'd7, 32'd2, "divu 7/2");
      do_op(MD_DIV,  32'd7, 32'hFFFFFFFE, "div 7/-2");
   endtask

   task automatic test_div_zero;
      do_op(MD_MTHI, 32'h1234, 32'd0, "mthi");
      do_op(MD_DIV,  32'd55, 32'd0, "div by zero");
      do_op(MD_DIVU, 32'd55, 32'd0, "divu by zero");
      do_op(MD_MFHI, 32'd0, 32'd0, "mfhi after div0");
   endtask

   task automatic test_reset_mid_op;
      do_op(MD_MTLO, 32'hCAFE0001, 32'd0, "mtlo pre-reset");
      @(negedge clk);
      start = 1'b1; md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
      @(negedge clk);
      start = 1'b0; md_op = MD_NONE;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_total++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
         $display("FAIL async reset mid-div: got busy=%b hi=%h lo=%h want 0", busy, hi, lo);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      do_op(MD_MULT, 32'd3, 32'd4, "mult 3x4 after reset");
   endtask

   task automatic test_back_to_back;
      int cnt;
      do_op(MD_MTHI, 32'h5555AAAA, 32'd0, "mthi pre-busy");
      void'(model_apply(MD_MULT, 32'h00010000, 32'h00010000));
      @(negedge clk);
      start = 1'b1; md_op = MD_MULT; rs_val = 32'h00010000; rt_val = 32'h00010000;
      @(negedge clk);
      md_op = MD_MTHI; rs_val = 32'hDEADBEEF;
      @(negedge clk);
      md_op = MD_DIV; rs_val = 32'd9; rt_val = 32'd4;
      @(negedge clk);
      md_op = MD_MTLO; rs_val = 32'hBADF00D5;
      @(negedge clk);
      start = 1'b0; md_op = MD_NONE;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      n_total++;
      if (busy !== 1'b0) $display("FAIL ignore-while-busy timeout: busy still %b", busy);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (hi !== m_hi || lo !== m_lo)
         $display("FAIL ignore-while-busy hi/lo: got %h_%h want %h_%h", hi, lo, m_hi, m_lo);
      else n_pass++;
   endtask

   task automatic test_madd;
      do_op(MD_MTHI,  32'd0, 32'd0, "madd setup hi");
      do_op(MD_MTLO,  32'hFFFFFFFF, 32'd0, "madd setup lo");
      do_op(MD_MADDU, 32'd1, 32'd1, "maddu 1x1");
      do_op(MD_MADD,  32'hFFFFFFFD, 32'd7, "madd -3x7");
      do_op(MD_MSUB,  32'hFFFFFFFF, 32'd5, "msub -1x5");
      do_op(MD_MSUBU, 32'hFFFFFFFF, 32'd5, "msubu");
   endtask

   task automatic test_random;
      logic [3:0]  ops [8];
      logic [3:0]  op;
      logic [31:0] a, b;
      ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO};
      for (int i = 0; i < 24; i++) begin
         op = ops[$urandom_range(7, 0)];
         a  = $urandom;
         b  = ($urandom_range(5, 0) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(3, 0) == 0) b = $urandom_range(9, 1);
         if (op == MD_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd2;
         do_op(op, a, b, $sformatf("random #%0d op%0d", i, op));
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_reset_mid_op();
      test_back_to_back();
      test_madd();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
